idelay_sweep_ctrl: RTL and testbench

- Drives the 5-bit tap value and load strobe of the sampling-clock IDELAYE2 (VAR_LOAD mode) that sits next to the MMCM clock generator.
- Steps the tap through a programmed window [tap_lo..tap_hi] in increments of step.
- At each tap it waits a settle time, then holds a dwell window (dwell_active) in which the downstream measurement/trigger logic captures data.
- Supports single-pass and continuous (wrapping) sweeps, with abort, and gates on IDELAYCTRL readiness.

---
 rtl/idelay_sweep_pkg.sv | 22 ++
 rtl/sync_2ff.sv | 25 ++
 rtl/idelay_sweep_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_idelay_sweep_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/idelay_sweep_pkg.sv
// Shared types, defaults and helpers for the IDELAYE2 tap sweep controller.
package idelay_sweep_pkg;

    localparam int TAP_W_DFLT   = 5;
    localparam int TAP_MAX_DFLT = 31;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_RDY = 3'd1,
        LOAD     = 3'd2,
        SETTLE   = 3'd3,
        DWELL    = 3'd4,
        NEXT     = 3'd5,
        DONE     = 3'd6
    } state_t;

    // Limit a requested tap to the highest legal tap of the delay line.
    function automatic int clamp_tap(input int v, input int vmax);
        return (v > vmax) ? vmax : v;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic single-bit two-flop synchroniser with asynchronous active-high reset.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic q_r;

    // Two-stage capture of the asynchronous input into the clk domain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_r <= 1'b0;
            q_r    <= 1'b0;
        end else begin
            meta_r <= d;
            q_r    <= meta_r;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/idelay_sweep_ctrl.sv
// Steps the sampling-clock IDELAYE2 tap through a programmed window, settling
// and then opening a dwell window at every tap. Outputs are registered from
// the next-state decode so they line up with the state register.
module idelay_sweep_ctrl
    import idelay_sweep_pkg::*;
#(
    parameter int TAP_W      = TAP_W_DFLT,
    parameter int TAP_MAX    = TAP_MAX_DFLT,
    parameter int SETTLE_CYC = 16,
    parameter int DWELL_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               dly_rdy,
    input  logic               start,
    input  logic               stop,
    input  logic               cont,
    input  logic [TAP_W-1:0]   tap_lo,
    input  logic [TAP_W-1:0]   tap_hi,
    input  logic [TAP_W-1:0]   step,
    input  logic [DWELL_W-1:0] dwell_len,
    output logic [TAP_W-1:0]   tap_out,
    output logic               ld,
    output logic               busy,
    output logic               dwell_active,
    output logic               done,
    output logic               aborted,
    output logic               cfg_err,
    output logic [DWELL_W-1:0] sweep_cnt
);

    localparam logic [DWELL_W-1:0] ONE_D    = DWELL_W'(1);
    localparam logic [DWELL_W-1:0] ZERO_D   = {DWELL_W{1'b0}};
    localparam logic [DWELL_W-1:0] SETTLE_D = DWELL_W'(SETTLE_CYC - 1);

    logic               rdy_s;
    state_t             state_r, state_s;
    logic [TAP_W-1:0]   cur_r, cur_s;
    logic [DWELL_W-1:0] cnt_r, cnt_s;
    logic [TAP_W-1:0]   lo_r, hi_r, step_r;
    logic               cont_r;
    logic [DWELL_W-1:0] dwell_r;
    logic [TAP_W-1:0]   lo_c_s, hi_c_s;
    logic [TAP_W:0]     nxt_s;
    logic               busy_state_s;
    logic               cfg_load_s, cfg_err_s, abort_s, wrap_s;

    logic [TAP_W-1:0]   tap_out_r;
    logic               ld_r, busy_r, dwell_active_r, done_r, aborted_r, cfg_err_r;
    logic [DWELL_W-1:0] sweep_cnt_r;

    sync_2ff u_rdy_sync (
        .clk (clk),
        .rst (rst),
        .d   (dly_rdy),
        .q   (rdy_s)
    );

    assign lo_c_s       = TAP_W'(clamp_tap(32'(tap_lo), TAP_MAX));
    assign hi_c_s       = TAP_W'(clamp_tap(32'(tap_hi), TAP_MAX));
    assign nxt_s        = {1'b0, cur_r} + {1'b0, step_r};
    assign busy_state_s = (state_r != IDLE) && (state_r != DONE);

    // Next-state, tap and counter decode; stop overrides every busy transition
    always_comb begin
        state_s    = state_r;
        cur_s      = cur_r;
        cnt_s      = cnt_r;
        cfg_load_s = 1'b0;
        cfg_err_s  = 1'b0;
        abort_s    = 1'b0;
        wrap_s     = 1'b0;
        if (busy_state_s && stop) begin
            state_s = IDLE;
            abort_s = 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start && !stop) begin
                        if ((lo_c_s > hi_c_s) || (step == {TAP_W{1'b0}})) begin
                            cfg_err_s = 1'b1;
                        end else begin
                            cfg_load_s = 1'b1;
                            cur_s      = lo_c_s;
                            state_s    = WAIT_RDY;
                        end
                    end else begin
                        state_s = IDLE;
                    end
                end
                WAIT_RDY: begin
                    if (rdy_s) begin
                        state_s = LOAD;
                    end else begin
                        state_s = WAIT_RDY;
                    end
                end
                LOAD: begin
                    if (!rdy_s) begin
                        state_s = WAIT_RDY;
                    end else begin
                        state_s = SETTLE;
                        cnt_s   = SETTLE_D;
                    end
                end
                SETTLE: begin
                    if (!rdy_s) begin
                        state_s = WAIT_RDY;
                    end else if (cnt_r == ZERO_D) begin
                        state_s = DWELL;
                        cnt_s   = dwell_r - ONE_D;
                    end else begin
                        cnt_s = cnt_r - ONE_D;
                    end
                end
                DWELL: begin
                    if (!rdy_s) begin
                        state_s = WAIT_RDY;
                    end else if (cnt_r == ZERO_D) begin
                        state_s = NEXT;
                    end else begin
                        cnt_s = cnt_r - ONE_D;
                    end
                end
                NEXT: begin
                    // Sum is one bit wider than the tap so large steps never alias
                    if (nxt_s <= {1'b0, hi_r}) begin
                        cur_s   = nxt_s[TAP_W-1:0];
                        state_s = LOAD;
                    end else if (cont_r) begin
                        cur_s   = lo_r;
                        wrap_s  = 1'b1;
                        state_s = LOAD;
                    end else begin
                        state_s = DONE;
                    end
                end
                DONE: begin
                    state_s = IDLE;
                end
                default: begin
                    state_s = IDLE;
                end
            endcase
        end
    end

    // State, tap, counter and captured configuration registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            cur_r   <= {TAP_W{1'b0}};
            cnt_r   <= ZERO_D;
            lo_r    <= {TAP_W{1'b0}};
            hi_r    <= {TAP_W{1'b0}};
            step_r  <= {TAP_W{1'b0}};
            cont_r  <= 1'b0;
            dwell_r <= ONE_D;
        end else begin
            state_r <= state_s;
            cur_r   <= cur_s;
            cnt_r   <= cnt_s;
            if (cfg_load_s) begin
                lo_r    <= lo_c_s;
                hi_r    <= hi_c_s;
                step_r  <= step;
                cont_r  <= cont;
                dwell_r <= (dwell_len == ZERO_D) ? ONE_D : dwell_len;
            end
        end
    end

    // Registered outputs decoded from the upcoming state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tap_out_r      <= {TAP_W{1'b0}};
            ld_r           <= 1'b0;
            busy_r         <= 1'b0;
            dwell_active_r <= 1'b0;
            done_r         <= 1'b0;
            aborted_r      <= 1'b0;
            cfg_err_r      <= 1'b0;
            sweep_cnt_r    <= ZERO_D;
        end else begin
            if (state_s == LOAD) begin
                tap_out_r <= cur_s;
            end
            ld_r           <= (state_s == LOAD);
            busy_r         <= (state_s != IDLE) && (state_s != DONE);
            dwell_active_r <= (state_s == DWELL);
            done_r         <= (state_s == DONE);
            aborted_r      <= abort_s;
            cfg_err_r      <= cfg_err_s;
            if (cfg_load_s) begin
                sweep_cnt_r <= ZERO_D;
            end else if (wrap_s) begin
                sweep_cnt_r <= sweep_cnt_r + ONE_D;
            end
        end
    end

    assign tap_out      = tap_out_r;
    assign ld           = ld_r;
    assign busy         = busy_r;
    assign dwell_active = dwell_active_r;
    assign done         = done_r;
    assign aborted      = aborted_r;
    assign cfg_err      = cfg_err_r;
    assign sweep_cnt    = sweep_cnt_r;

endmodule

// File: tb/tb_idelay_sweep_ctrl.sv
// Scoreboard bench for idelay_sweep_ctrl: a sweep model pushes the expected
// event stream (loads, dwell runs, done/abort/cfg_err) and a negedge monitor
// pops and compares as the DUT produces each event.
module tb_idelay_sweep_ctrl;

    localparam int TAP_W   = 5;
    localparam int DWELL_W = 16;
    localparam int SETTLE  = 4;

    localparam int K_LD    = 0;
    localparam int K_DW    = 1;
    localparam int K_DONE  = 2;
    localparam int K_ABORT = 3;
    localparam int K_CFG   = 4;

    typedef struct {
        int kind;
        int tap;
        int scnt;
        int dlen;
    } ev_t;

    logic               clk = 1'b0;
    logic               rst, dly_rdy, start, stop, cont;
    logic [TAP_W-1:0]   tap_lo, tap_hi, step;
    logic [DWELL_W-1:0] dwell_len;
    logic [TAP_W-1:0]   tap_out;
    logic               ld, busy, dwell_active, done, aborted, cfg_err;
    logic [DWELL_W-1:0] sweep_cnt;

    ev_t exp_q[$];
    int  n_vec = 0;
    int  n_err = 0;
    int  ld_seen = 0;
    int  dwell_starts = 0;
    bit  prev_dw;
    int  run_len, gap, gap_at_start, since_fall, rdy_low;

    idelay_sweep_ctrl #(.TAP_W(TAP_W), .TAP_MAX(31), .SETTLE_CYC(SETTLE), .DWELL_W(DWELL_W)) dut (
        .clk(clk), .rst(rst), .dly_rdy(dly_rdy), .start(start), .stop(stop), .cont(cont),
        .tap_lo(tap_lo), .tap_hi(tap_hi), .step(step), .dwell_len(dwell_len),
        .tap_out(tap_out), .ld(ld), .busy(busy), .dwell_active(dwell_active), .done(done),
        .aborted(aborted), .cfg_err(cfg_err), .sweep_cnt(sweep_cnt)
    );

    always #5 clk = ~clk;

    function automatic string kname(input int k);
        case (k)
            K_LD:    return "ld";
            K_DW:    return "dwell";
            K_DONE:  return "done";
            K_ABORT: return "aborted";
            K_CFG:   return "cfg_err";
            default: return "none";
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic pop_ev(input int kind, output ev_t e, output bit ok);
        n_vec++;
        ok = 1'b0;
        e = '{kind: -1, tap: 0, scnt: 0, dlen: 0};
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL event_order: got %s, required none (t=%0t)", kname(kind), $time);
        end else if (exp_q[0].kind != kind) begin
            n_err++;
            $display("FAIL event_order: got %s, required %s (t=%0t)", kname(kind), kname(exp_q[0].kind), $time);
        end else begin
            e = exp_q.pop_front();
            ok = 1'b1;
        end
    endtask

    task automatic push(input int k, input int t, input int s, input int d);
        exp_q.push_back('{kind: k, tap: t, scnt: s, dlen: d});
    endtask

    // Behavioural sweep: walk the window, wrap or finish, truncate at a stop,
    // and repeat one load where readiness is lost before that tap's dwell.
    task automatic push_model(input int lo, input int hi, input int stp, input int dl,
                              input bit c, input int stop_after, input int reload_at);
        int lo_c, hi_c, eff, cnt, pass, t, last;
        lo_c = (lo > 31) ? 31 : lo;
        hi_c = (hi > 31) ? 31 : hi;
        eff  = (dl == 0) ? 1 : dl;
        cnt  = 0;
        pass = 0;
        last = lo_c;
        if (lo_c > hi_c || stp == 0) begin
            push(K_CFG, 0, 0, 0);
            return;
        end
        forever begin
            t = lo_c;
            while (t <= hi_c) begin
                push(K_LD, t, pass % 65536, 0);
                cnt++;
                if (cnt == stop_after) begin
                    push(K_ABORT, t, 0, 0);
                    return;
                end
                if (cnt == reload_at) push(K_LD, t, pass % 65536, 0);
                push(K_DW, 0, 0, eff);
                last = t;
                t += stp;
            end
            if (!c) begin
                push(K_DONE, last, 0, 0);
                return;
            end
            pass++;
        end
    endtask

    // Monitor: classify DUT events each negedge and compare against the queue
    always @(negedge clk) begin
        ev_t e;
        bit  ok;
        if (rst) begin
            prev_dw = 1'b0; run_len = 0; gap = 0; gap_at_start = 0; since_fall = 100; rdy_low = 0;
        end else begin
            since_fall++;
            rdy_low = dly_rdy ? 0 : rdy_low + 1;
            if (rdy_low >= 3) chk("dwell_while_unready", int'(dwell_active), 0);
            if (ld) begin
                ld_seen++;
                gap = 0;
                pop_ev(K_LD, e, ok);
                if (ok) begin
                    chk("ld_tap_out", int'(tap_out), e.tap);
                    chk("ld_sweep_cnt", int'(sweep_cnt), e.scnt);
                end
            end else begin
                gap++;
            end
            if (dwell_active && !prev_dw) begin
                dwell_starts++;
                run_len = 1;
                gap_at_start = gap;
            end else if (dwell_active) begin
                run_len++;
            end
            if (!dwell_active && prev_dw && !aborted) begin
                since_fall = 0;
                pop_ev(K_DW, e, ok);
                if (ok) begin
                    chk("dwell_len", run_len, e.dlen);
                    chk("settle_gap", gap_at_start, SETTLE + 1);
                end
            end
            if (done) begin
                pop_ev(K_DONE, e, ok);
                if (ok) begin
                    chk("done_tap_out", int'(tap_out), e.tap);
                    chk("done_busy", int'(busy), 0);
                    chk("done_latency", since_fall, 1);
                end
            end
            if (aborted) begin
                pop_ev(K_ABORT, e, ok);
                if (ok) begin
                    chk("abort_tap_out", int'(tap_out), e.tap);
                    chk("abort_busy", int'(busy), 0);
                    chk("abort_dwell", int'(dwell_active), 0);
                end
            end
            if (cfg_err) begin
                pop_ev(K_CFG, e, ok);
                if (ok) chk("cfg_err_busy", int'(busy), 0);
            end
            prev_dw = dwell_active;
        end
    end

    task automatic wait_ld(input int n);
        for (int i = 0; i < 5000 && ld_seen < n; i++) begin
            @(negedge clk); #1;
        end
        if (ld_seen < n) chk("wait_ld_timeout", ld_seen, n);
    endtask

    task automatic wait_dw(input int n);
        for (int i = 0; i < 5000 && dwell_starts < n; i++) begin
            @(negedge clk); #1;
        end
        if (dwell_starts < n) chk("wait_dwell_timeout", dwell_starts, n);
    endtask

    task automatic wait_idle();
        int i;
        for (i = 0; i < 6000; i++) begin
            if (exp_q.size() == 0 && !busy) break;
            @(negedge clk); #1;
        end
        if (i == 6000) begin
            chk("idle_timeout_pending", exp_q.size(), 0);
            exp_q.delete();
        end
        repeat (3) begin
            @(negedge clk); #1;
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_tap_out"}, int'(tap_out), 0);
        chk({tag, "_ld"}, int'(ld), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_dwell"}, int'(dwell_active), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_aborted"}, int'(aborted), 0);
        chk({tag, "_cfg_err"}, int'(cfg_err), 0);
        chk({tag, "_sweep_cnt"}, int'(sweep_cnt), 0);
    endtask

    task automatic issue_start(input int lo, input int hi, input int stp, input int dl, input bit c);
        @(negedge clk); #1;
        tap_lo = TAP_W'(lo); tap_hi = TAP_W'(hi); step = TAP_W'(stp);
        dwell_len = DWELL_W'(dl); cont = c; start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
    endtask

    // One sweep: model first, then stimulus; optional stop, readiness drop
    // before the reload_at-th tap's dwell, and an ignored start while busy.
    task automatic run_sweep(input int lo, input int hi, input int stp, input int dl, input bit c,
                             input int stop_after, input bit stop_in_dwell, input int reload_at,
                             input bit poke);
        int base_ld, base_dw;
        base_ld = ld_seen;
        base_dw = dwell_starts;
        push_model(lo, hi, stp, dl, c, stop_after, reload_at);
        issue_start(lo, hi, stp, dl, c);
        if (poke) begin
            wait_dw(base_dw + 1);
            tap_lo = 5'd0; tap_hi = 5'd31; step = 5'd1; start = 1'b1;
            @(negedge clk); #1;
            start = 1'b0;
        end
        if (reload_at > 0) begin
            wait_ld(base_ld + reload_at);
            @(negedge clk); #1;
            dly_rdy = 1'b0;
            repeat (10) @(negedge clk);
            #1 dly_rdy = 1'b1;
        end
        if (stop_after > 0) begin
            if (stop_in_dwell) wait_dw(base_dw + stop_after);
            else               wait_ld(base_ld + stop_after);
            stop = 1'b1;
            @(negedge clk); #1;
            stop = 1'b0;
        end
        wait_idle();
    endtask

    initial begin
        int lo, hi, stp, dl, sa, base_dw;
        bit c;
        rst = 1'b1; dly_rdy = 1'b1; start = 1'b0; stop = 1'b0; cont = 1'b0;
        tap_lo = 5'd0; tap_hi = 5'd0; step = 5'd0; dwell_len = 16'd0;
        repeat (3) @(negedge clk);
        #1 check_zero("reset");
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;

        // Single pass 2,6,10 with an ignored start mid-sweep
        run_sweep(2, 10, 4, 3, 1'b0, 0, 1'b0, 0, 1'b1);
        // Continuous wrap 0,8,16,24,0,8 then stop on the sixth load
        run_sweep(0, 31, 8, 2, 1'b1, 6, 1'b0, 0, 1'b0);
        // Configuration errors
        run_sweep(12, 5, 1, 3, 1'b0, 0, 1'b0, 0, 1'b0);
        run_sweep(3, 9, 0, 3, 1'b0, 0, 1'b0, 0, 1'b0);
        // Abort during the second dwell
        run_sweep(2, 10, 4, 3, 1'b0, 2, 1'b1, 0, 1'b0);
        // Readiness loss mid-settle at tap 6
        run_sweep(2, 10, 4, 3, 1'b0, 0, 1'b0, 2, 1'b0);
        // Largest step from near the top: no modular wrap, dwell_len 0 -> 1
        run_sweep(30, 31, 31, 0, 1'b0, 0, 1'b0, 0, 1'b0);

        // Start and stop together in IDLE are both ignored
        @(negedge clk); #1;
        tap_lo = 5'd1; tap_hi = 5'd4; step = 5'd1; start = 1'b1; stop = 1'b1;
        @(negedge clk); #1;
        start = 1'b0; stop = 1'b0;
        repeat (4) begin
            @(negedge clk); #1;
            chk("start_stop_busy", int'(busy), 0);
        end

        // Asynchronous reset mid-dwell, then a clean sweep from tap_lo
        base_dw = dwell_starts;
        push_model(2, 10, 4, 3, 1'b0, 0, 0);
        issue_start(2, 10, 4, 3, 1'b0);
        wait_dw(base_dw + 2);
        @(negedge clk); #2;
        rst = 1'b1;
        #1 check_zero("async_rst");
        exp_q.delete();
        @(negedge clk); #1;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        run_sweep(2, 10, 4, 3, 1'b0, 0, 1'b0, 0, 1'b0);

        // Randomised configurations
        for (int k = 0; k < 10; k++) begin
            lo  = int'($urandom_range(0, 31));
            hi  = int'($urandom_range(0, 31));
            stp = int'($urandom_range(0, 12));
            dl  = int'($urandom_range(0, 4));
            c   = 1'($urandom_range(0, 1));
            sa  = c ? int'($urandom_range(1, 10)) : 0;
            run_sweep(lo, hi, stp, dl, c, sa, 1'b0, 0, 1'b0);
        end

        chk("final_queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
